// File: rtl/mandelbrot_iter_engine.sv
// mandelbrot_iter_engine
//   Iterates z <- z^2 + c for one point per job at one iteration per clock and
//   returns the iteration count, an escape flag and a pass-through pixel tag.
//   Fixed point: WIDTH-bit two's complement with FRAC fractional bits.
//
// Ports
//   clock        sole clock, rising edge
//   reset        synchronous, active-high
//   in_valid     request valid
//   in_ready     engine can accept a request (high only when idle)
//   in_c_r       real part of c (signed fixed point)
//   in_c_i       imaginary part of c (signed fixed point)
//   in_max_iter  iteration limit
//   in_tag       opaque tag returned with the result
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   out_iter     final iteration count
//   out_escaped  1 = escape detected, 0 = limit reached
//   out_tag      tag captured at accept
//   busy         a job is iterating or waiting for its result to be taken
module mandelbrot_iter_engine #(
  parameter int WIDTH  = 27,
  parameter int FRAC   = 23,
  parameter int ITER_W = 16,
  parameter int TAG_W  = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_c_r,
  input  logic [WIDTH-1:0]  in_c_i,
  input  logic [ITER_W-1:0] in_max_iter,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_escaped,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  // Escape thresholds need at least 3 integer bits plus sign to hold 4.0.
  generate
    if (WIDTH - FRAC < 4) begin : g_int_check
      $error("mandelbrot_iter_engine: WIDTH-FRAC must be at least 4");
    end
  endgenerate

  localparam logic signed [WIDTH-1:0] TWO     = WIDTH'(2) << FRAC;
  localparam logic signed [WIDTH-1:0] NEG_TWO = -TWO;
  localparam logic signed [WIDTH:0]   FOUR    = (WIDTH + 1)'(4) << FRAC;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  // Fixed-point multiply: full-width signed product, truncated toward -inf,
  // keeping the product sign bit above the retained magnitude bits.
  function automatic logic signed [WIDTH-1:0] fx_mul(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [2*WIDTH-1:0] p;
    p = a * b;
    return {p[2*WIDTH-1], p[WIDTH+FRAC-2:FRAC]};
  endfunction

  state_t                   state_q;
  logic signed [WIDTH-1:0]  c_r_q, c_i_q;
  logic signed [WIDTH-1:0]  z_r_q, z_i_q;
  logic signed [WIDTH-1:0]  z_r_d, z_i_d;
  logic [ITER_W-1:0]        max_q, cnt_q;
  logic [TAG_W-1:0]         tag_q;
  logic                     in_ready_q, busy_q, out_valid_q, out_esc_q;
  logic [ITER_W-1:0]        out_iter_q;
  logic [TAG_W-1:0]         out_tag_q;

  logic signed [WIDTH-1:0]  zr_sq, zi_sq, zr_zi;
  logic signed [WIDTH:0]    mag_sum;
  logic                     esc;
  logic                     at_limit;

  // Escape test and next z, both from the registered z of the current step.
  always_comb begin
    zr_sq   = fx_mul(z_r_q, z_r_q);
    zi_sq   = fx_mul(z_i_q, z_i_q);
    zr_zi   = fx_mul(z_r_q, z_i_q);
    // One extra bit so |z|^2 up to 8 cannot wrap before the compare.
    mag_sum = {zr_sq[WIDTH-1], zr_sq} + {zi_sq[WIDTH-1], zi_sq};
    esc     = (z_r_q > TWO) || (z_r_q < NEG_TWO) ||
              (z_i_q > TWO) || (z_i_q < NEG_TWO) ||
              (mag_sum > FOUR);
    at_limit = (cnt_q == max_q);
    z_r_d   = zr_sq - zi_sq + c_r_q;
    z_i_d   = (zr_zi <<< 1) + c_i_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_iter_q  <= '0;
      out_esc_q   <= 1'b0;
      out_tag_q   <= '0;
      z_r_q       <= '0;
      z_i_q       <= '0;
      cnt_q       <= '0;
      c_r_q       <= '0;
      c_i_q       <= '0;
      max_q       <= '0;
      tag_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            c_r_q      <= in_c_r;
            c_i_q      <= in_c_i;
            max_q      <= in_max_iter;
            tag_q      <= in_tag;
            z_r_q      <= '0;
            z_i_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_ITER;
          end
        end
        S_ITER: begin
          // Escape wins over the limit when both hold on the same step.
          if (esc || at_limit) begin
            out_iter_q  <= cnt_q;
            out_esc_q   <= esc;
            out_tag_q   <= tag_q;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            z_r_q <= z_r_d;
            z_i_q <= z_i_d;
            cnt_q <= cnt_q + ITER_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign out_iter    = out_iter_q;
  assign out_escaped = out_esc_q;
  assign out_tag     = out_tag_q;

endmodule
